// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the fetch-stage controller.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // HOLD: nothing outstanding; WAIT: one live request; KILL: one stale request.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  function automatic logic req_outstanding(input fetch_state_t s);
    return (s == WAIT) || (s == KILL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_wait_timer
// Purpose  : Saturating response-wait counter with a sticky timeout flag.
// Revision : 1.0
// ============================================================================
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] count_q, count_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    count_d   = count_q;
    timeout_d = timeout_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != MAX_C)) begin
      count_d = count_q + CW'(1);
    end
    // Flag rises on the same edge the counter lands on MAX_WAIT.
    if (count_d == MAX_C) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : One-outstanding-request fetch sequencer with a one-entry decode
//            slot, redirect squash of stale responses and a wait timeout.
// Revision : 1.0
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_d,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  input  logic [XLEN-1:0] next_pc_f,
  output logic [XLEN-1:0] pc_f,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            valid_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic            fetch_timeout
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_nx;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            slot_valid_q, slot_valid_d;
  logic [XLEN-1:0] slot_instr_q, slot_instr_d;
  logic [XLEN-1:0] slot_pc_q, slot_pc_d;
  logic            issue;

  // Reset gating keeps the bus quiet while the register file is held in reset.
  assign issue = reset && (state_q == HOLD) && !redirect_e &&
                 (!slot_valid_q || !stall_d);

  always_comb begin
    state_d       = state_q;
    pc_nx         = pc_q;
    inflight_pc_d = inflight_pc_q;
    slot_valid_d  = slot_valid_q;
    slot_instr_d  = slot_instr_q;
    slot_pc_d     = slot_pc_q;

    if (slot_valid_q && !stall_d) begin
      slot_valid_d = 1'b0;
    end

    unique case (state_q)
      HOLD: begin
        if (issue) begin
          inflight_pc_d = pc_q;
          pc_nx         = next_pc_f;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = HOLD;
          if (!redirect_e) begin
            slot_valid_d = 1'b1;
            slot_instr_d = imem_rdata;
            slot_pc_d    = inflight_pc_q;
          end
        end else if (redirect_e) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (imem_rvalid) begin
          state_d = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase

    // Redirect wins over everything: retarget and squash the slot.
    if (redirect_e) begin
      pc_nx        = redirect_pc_e;
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HOLD;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      slot_valid_q  <= 1'b0;
      slot_instr_q  <= '0;
      slot_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_nx;
      inflight_pc_q <= inflight_pc_d;
      slot_valid_q  <= slot_valid_d;
      slot_instr_q  <= slot_instr_d;
      slot_pc_q     <= slot_pc_d;
    end
  end

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (issue),
    .enable_i  (req_outstanding(state_q)),
    .timeout_o (fetch_timeout)
  );

  assign pc_f      = pc_q;
  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign valid_d   = slot_valid_q;
  assign instr_d   = slot_instr_q;
  assign pc_d      = slot_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed self-checking bench for fetch_ctrl.
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall_d;
  logic        redirect_e;
  logic [31:0] redirect_pc_e;
  logic [31:0] next_pc_f;
  logic [31:0] pc_f;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        fetch_timeout;

  int n_chk;
  int n_pass;

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_d       (stall_d),
    .redirect_e    (redirect_e),
    .redirect_pc_e (redirect_pc_e),
    .next_pc_f     (next_pc_f),
    .pc_f          (pc_f),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .valid_d       (valid_d),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .fetch_timeout (fetch_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequential predictor.
  always_comb next_pc_f = pc_f + 32'd4;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (pc_f !== 32'h0) $display("FAIL rst_pc_f got=%h exp=0", pc_f); else n_pass++;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", imem_req); else n_pass++;
    n_chk++; if (valid_d !== 1'b0) $display("FAIL rst_valid got=%b exp=0", valid_d); else n_pass++;
    n_chk++; if (instr_d !== 32'h0) $display("FAIL rst_instr got=%h exp=0", instr_d); else n_pass++;
    n_chk++; if (pc_d !== 32'h0) $display("FAIL rst_pc_d got=%h exp=0", pc_d); else n_pass++;
    n_chk++; if (fetch_timeout !== 1'b0) $display("FAIL rst_timeout got=%b exp=0", fetch_timeout); else n_pass++;
  endtask

  task automatic test_stream();
    reset = 1'b1; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL s0_req got=%b/%h exp=1/0", imem_req, imem_addr); else n_pass++;
    next_cycle(); imem_rvalid = 1'b1; imem_rdata = ins(32'h0); #1;
    n_chk++; if (imem_req !== 1'b0 || valid_d !== 1'b0) $display("FAIL s1_idle got=%b/%b exp=0/0", imem_req, valid_d); else n_pass++;
    next_cycle(); imem_rvalid = 1'b0; #1;
    n_chk++; if (valid_d !== 1'b1 || pc_d !== 32'h0 || instr_d !== ins(32'h0)) $display("FAIL s2_slot got=%b/%h/%h exp=1/0/%h", valid_d, pc_d, instr_d, ins(32'h0)); else n_pass++;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL s2_req got=%b/%h exp=1/4", imem_req, imem_addr); else n_pass++;
    next_cycle(); imem_rvalid = 1'b1; imem_rdata = ins(32'h4); #1;
    n_chk++; if (imem_req !== 1'b0 || valid_d !== 1'b0) $display("FAIL s3_idle got=%b/%b exp=0/0", imem_req, valid_d); else n_pass++;
  endtask

  task automatic test_stall();
    next_cycle(); imem_rvalid = 1'b0; stall_d = 1'b1; #1;
    n_chk++; if (valid_d !== 1'b1 || pc_d !== 32'h4 || imem_req !== 1'b0) $display("FAIL st0 got=%b/%h/%b exp=1/4/0", valid_d, pc_d, imem_req); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      n_chk++; if (imem_req !== 1'b0 || valid_d !== 1'b1 || pc_d !== 32'h4 || instr_d !== ins(32'h4))
        $display("FAIL st_hold%0d got=%b/%b/%h/%h exp=0/1/4/%h", i, imem_req, valid_d, pc_d, instr_d, ins(32'h4)); else n_pass++;
    end
    next_cycle(); stall_d = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL st_release got=%b/%h exp=1/8", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    next_cycle(); redirect_e = 1'b1; redirect_pc_e = 32'h100; #1;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rw0_req got=%b exp=0", imem_req); else n_pass++;
    next_cycle(); redirect_e = 1'b0; #1;
    n_chk++; if (pc_f !== 32'h100 || valid_d !== 1'b0 || imem_req !== 1'b0) $display("FAIL rw1 got=%h/%b/%b exp=100/0/0", pc_f, valid_d, imem_req); else n_pass++;
    next_cycle(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rw2_req got=%b exp=0", imem_req); else n_pass++;
    next_cycle(); imem_rvalid = 1'b0; #1;
    n_chk++; if (valid_d !== 1'b0) $display("FAIL rw3_valid got=%b exp=0", valid_d); else n_pass++;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL rw3_req got=%b/%h exp=1/100", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_redirect_same();
    next_cycle(); imem_rvalid = 1'b1; imem_rdata = ins(32'h100); redirect_e = 1'b1; redirect_pc_e = 32'h200; #1;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rs0_req got=%b exp=0", imem_req); else n_pass++;
    next_cycle(); imem_rvalid = 1'b0; redirect_e = 1'b0; #1;
    n_chk++; if (valid_d !== 1'b0) $display("FAIL rs1_valid got=%b exp=0", valid_d); else n_pass++;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL rs1_req got=%b/%h exp=1/200", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 15; i++) begin
      next_cycle(); #1;
      n_chk++; if (fetch_timeout !== 1'b0 || imem_req !== 1'b0) $display("FAIL to_wait%0d got=%b/%b exp=0/0", i, fetch_timeout, imem_req); else n_pass++;
    end
    next_cycle(); imem_rvalid = 1'b1; imem_rdata = ins(32'h200); #1;
    n_chk++; if (fetch_timeout !== 1'b1) $display("FAIL to_rise got=%b exp=1", fetch_timeout); else n_pass++;
    next_cycle(); imem_rvalid = 1'b0; #1;
    n_chk++; if (valid_d !== 1'b1 || pc_d !== 32'h200 || instr_d !== ins(32'h200)) $display("FAIL to_slot got=%b/%h/%h exp=1/200/%h", valid_d, pc_d, instr_d, ins(32'h200)); else n_pass++;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) $display("FAIL to_req got=%b/%h exp=1/204", imem_req, imem_addr); else n_pass++;
    next_cycle(); #1;
    n_chk++; if (fetch_timeout !== 1'b1 || valid_d !== 1'b0) $display("FAIL to_sticky got=%b/%b exp=1/0", fetch_timeout, valid_d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b0; #1;
    n_chk++; if (pc_f !== 32'h0 || valid_d !== 1'b0 || pc_d !== 32'h0 || instr_d !== 32'h0) $display("FAIL rm_async got=%h/%b/%h/%h exp=0/0/0/0", pc_f, valid_d, pc_d, instr_d); else n_pass++;
    n_chk++; if (fetch_timeout !== 1'b0 || imem_req !== 1'b0) $display("FAIL rm_flags got=%b/%b exp=0/0", fetch_timeout, imem_req); else n_pass++;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
    next_cycle(); #1;
    n_chk++; if (imem_req !== 1'b0 || valid_d !== 1'b0) $display("FAIL rm_held got=%b/%b exp=0/0", imem_req, valid_d); else n_pass++;
    reset = 1'b1; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rm_first got=%b/%h exp=1/0", imem_req, imem_addr); else n_pass++;
    next_cycle(); imem_rvalid = 1'b0; #1;
    n_chk++; if (valid_d !== 1'b0 || imem_req !== 1'b0) $display("FAIL rm_late got=%b/%b exp=0/0", valid_d, imem_req); else n_pass++;
    next_cycle(); imem_rvalid = 1'b1; imem_rdata = ins(32'h0); #1;
    next_cycle(); imem_rvalid = 1'b0; #1;
    n_chk++; if (valid_d !== 1'b1 || pc_d !== 32'h0 || instr_d !== ins(32'h0) || fetch_timeout !== 1'b0)
      $display("FAIL rm_fill got=%b/%h/%h/%b exp=1/0/%h/0", valid_d, pc_d, instr_d, fetch_timeout, ins(32'h0)); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; stall_d = 1'b0; redirect_e = 1'b0; redirect_pc_e = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_same();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the fetch stage. It replaces the free-running PC/IF-ID pair with a request/response engine that issues one instruction-memory request at a time and tolerates variable memory latency. It holds fetched instructions in a one-entry decode slot under decode stall, and discards stale responses after an EX-stage redirect. It sits between the branch predictor / next-PC mux (which supplies `next_pc_f` from `pc_f`) and the decode stage.

## Interface
- `RESET_PC`, `32'h0000_0000`, first fetch address after reset.
- `MAX_WAIT`, `15`, response-wait cycles before `fetch_timeout` is raised (≥1).

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall_d`  in  1  decode cannot accept the slot this cycle.
- `redirect_e`  in  1  EX redirect (mispredict or resolved correction).
- `redirect_pc_e`  in  32  redirect target; valid with `redirect_e`.
- `next_pc_f`  in  32  predicted successor of `pc_f`, combinational from predictor.
- `pc_f`  out  32  address of the next request to issue.
- `imem_req`  out  1  single-cycle issue pulse.
- `imem_addr`  out  32  request address, equals `pc_f` when `imem_req`=1.
- `imem_rvalid`  in  1  response valid, ≥1 cycle after issue.
- `imem_rdata`  in  32  response instruction.
- `valid_d`  out  1  decode slot holds a valid instruction.
- `instr_d`  out  32  slot instruction.
- `pc_d`  out  32  slot instruction PC.
- `fetch_timeout`  out  1  sticky: a response exceeded `MAX_WAIT` cycles.

## Operation
- States: `HOLD` (no request outstanding), `WAIT` (one request outstanding), `KILL` (outstanding request whose response must be discarded). Reset state `HOLD`.
- Slot is consumed when `valid_d && !stall_d`.
- `imem_req` = `state==HOLD && !redirect_e && (!valid_d || !stall_d)`. It is forced 0 while `reset` is low.
- On issue:
  - `inflight_pc <= pc_f`.
  - `pc_f <= next_pc_f`.
  - → `WAIT`.
- `WAIT`, `imem_rvalid`, no redirect:
  - `valid_d <= 1`, `instr_d <= imem_rdata`, `pc_d <= inflight_pc`.
  - → `HOLD`.
  - The slot is empty by construction, because issue required it to be free or draining.
- `WAIT` and no `imem_rvalid`: stay.
- Redirect, in any state:
  - `pc_f <= redirect_pc_e`.
  - `valid_d <= 0`.
  - Any response arriving the same cycle is dropped.
- Redirect in `WAIT` without `imem_rvalid` → `KILL`. With `imem_rvalid` → `HOLD`.
- `KILL`:
  - `imem_rvalid` is discarded, → `HOLD`.
  - A further redirect only updates `pc_f`.
- Slot consumed with no refill that cycle → `valid_d <= 0`.
- Wait counter:
  - Width `$clog2(MAX_WAIT+1)`.
  - Cleared on issue; increments each cycle in `WAIT`/`KILL`; saturates at `MAX_WAIT`.
  - At `MAX_WAIT`, `fetch_timeout <= 1`. It is cleared only by reset.
- All arithmetic on PCs is external. The block never adds to `pc_f`.

## Timing
- Reset values: state `HOLD`, `pc_f=RESET_PC`, `valid_d=0`, `instr_d=0`, `pc_d=0`, `fetch_timeout=0`, counter 0, `imem_req=0`.
- First `imem_req` in the first cycle `reset` is high.
- Latency with 1-cycle memory:
  - Issue at cycle t, `imem_rvalid` at t+1, `valid_d` at t+2.
  - Next issue at t+2 if decode drains.
  - Peak throughput is one instruction per 2 cycles.
- Decode stall holds `valid_d`/`instr_d`/`pc_d` stable and blocks issue.
- Redirect to issue latency:
  - From `HOLD`: 1 cycle, first request is to `redirect_pc_e`.
  - From `WAIT`: stale response arrival + 1.
- Reset asserted mid-request: everything returns to reset values immediately. A response arriving after reset release with no request outstanding is ignored (`HOLD` ignores `imem_rvalid`).

## Structure
- `fetch_pkg`:
  - State enum `fetch_state_t {HOLD, WAIT, KILL}`.
  - Default `RESET_PC` constant.
  - `XLEN=32`.
- Sub-module `fetch_wait_timer`: the saturating wait counter plus sticky timeout flag, with clear/enable inputs.
- Everything else stays in `fetch_ctrl`.

## Test plan
- Reset release, 1-cycle memory, `next_pc_f=pc_f+4`, no stall:
  - Requests at 0x0, 0x4, 0x8 on every other cycle.
  - `valid_d` with `pc_d`=0x0, 0x4, 0x8 in order.
- Slot valid (`pc_d`=0x4), `stall_d` high 3 cycles:
  - No `imem_req`; `instr_d`/`pc_d` stable.
  - Request at 0x8 in the cycle `stall_d` falls.
- Request to 0x8 outstanding, `redirect_e` with target 0x100, response 2 cycles later:
  - Response dropped, `valid_d` stays 0.
  - Next `imem_req` at 0x100 one cycle after the stale response.
- `redirect_e` in the same cycle as `imem_rvalid`:
  - Data discarded, `valid_d=0`.
  - `imem_req` at the redirect target next cycle.
- Memory withholds `imem_rvalid` for 16 cycles:
  - `fetch_timeout` rises after 15 waiting cycles and stays high after the response.
  - It is cleared only by driving `reset` low.
- `reset` driven low while in `WAIT`:
  - Outputs return to reset values asynchronously.
  - A late `imem_rvalid` after release is ignored.
  - First request after release is at `RESET_PC`.
